// File: rtl/crc_pkg.sv
// -----------------------------------------------------------------------------
// crc_pkg
// Shared definitions for the streaming CRC pipeline:
//   - crc_state_t : message FSM states (IDLE / ACCUM / HOLD)
//   - BEAT_W      : width of the saturating per-message beat counter
//   - MIN_/MAX_*  : legal ranges of the CRC, data and output-stage parameters
// -----------------------------------------------------------------------------
package crc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } crc_state_t;

  localparam int unsigned BEAT_W         = 16;
  localparam int unsigned MIN_WIDTH      = 4;
  localparam int unsigned MAX_WIDTH      = 32;
  localparam int unsigned MIN_DATA_W     = 8;
  localparam int unsigned MAX_DATA_W     = 64;
  localparam int unsigned MAX_OUT_STAGES = 4;

endpackage

// File: rtl/crc_stream_pipe_step.sv
// -----------------------------------------------------------------------------
// crc_step
// Combinational CRC update: a bit-serial MSB-first LFSR of p_width bits
// unrolled over all p_data_w data bits, so one call consumes a whole beat.
//
// Parameters : p_width   - CRC register width
//              p_polynom - generator polynomial without the implicit top bit
//              p_data_w  - data bits consumed per call
// Ports      : crc       - current accumulator
//              data      - beat data, bit p_data_w-1 shifted in first
//              next_crc  - accumulator after consuming all data bits
// -----------------------------------------------------------------------------
module crc_step #(
  parameter int unsigned        p_width   = 8,
  parameter logic [p_width-1:0] p_polynom = p_width'(32'h31),
  parameter int unsigned        p_data_w  = 8
) (
  input  logic [p_width-1:0]  crc,
  input  logic [p_data_w-1:0] data,
  output logic [p_width-1:0]  next_crc
);

  always_comb begin
    logic [p_width-1:0] c;
    logic               fb;
    c  = crc;
    fb = 1'b0;
    for (int i = int'(p_data_w) - 1; i >= 0; i--) begin
      fb = c[p_width-1] ^ data[i];
      c  = {c[p_width-2:0], 1'b0} ^ (fb ? p_polynom : '0);
    end
    next_crc = c;
  end

endmodule

// File: rtl/crc_stream_pipe.sv
// -----------------------------------------------------------------------------
// crc_stream_pipe
// Streaming CRC engine. Accepts framed message beats (in_sof / in_last),
// accumulates a CRC one beat per cycle and delivers one result per message
// through a stall-all output pipeline of 1 + p_out_stages registers.
//
// Optional feature macro: CRC_REFLECT_EN
//   defined   : each input byte is bit-reversed before the step and the final
//               accumulator is bit-reversed over p_width before the xorout.
//   undefined : plain MSB-first, non-reflected CRC (no reflection logic).
//
// Ports:
//   clk        in   single clock, rising edge
//   rstN       in   asynchronous active-low reset
//   in_valid   in   beat present
//   in_ready   out  beat accepted when in_valid && in_ready
//   in_data    in   p_data_w message bits, MSB first
//   in_sof     in   first beat of a message (restarts a partial one)
//   in_last    in   final beat of a message
//   out_valid  out  out_crc / out_beats valid
//   out_ready  in   downstream accepts the result
//   out_crc    out  final CRC (p_width bits)
//   out_beats  out  accepted beats in the message, saturating at 16'hFFFF
//   err_pulse  out  one-cycle pulse on a framing error
// -----------------------------------------------------------------------------
module crc_stream_pipe
  import crc_pkg::*;
#(
  parameter int unsigned        p_width      = 8,
  parameter logic [p_width-1:0] p_polynom    = p_width'(32'h31),
  parameter logic [p_width-1:0] p_init       = '0,
  parameter logic [p_width-1:0] p_xorout     = '0,
  parameter int unsigned        p_data_w     = 8,
  parameter int unsigned        p_out_stages = 1
) (
  input  logic                clk,
  input  logic                rstN,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [p_data_w-1:0] in_data,
  input  logic                in_sof,
  input  logic                in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [p_width-1:0]  out_crc,
  output logic [BEAT_W-1:0]   out_beats,
  output logic                err_pulse
);

  localparam int unsigned LAST = p_out_stages;

  function automatic logic [BEAT_W-1:0] sat_inc(input logic [BEAT_W-1:0] v);
    return (&v) ? v : v + BEAT_W'(1);
  endfunction

`ifdef CRC_REFLECT_EN
  function automatic logic [p_data_w-1:0] reflect_bytes(input logic [p_data_w-1:0] d);
    logic [p_data_w-1:0] r;
    r = '0;
    for (int b = 0; b < int'(p_data_w / 8); b++)
      for (int i = 0; i < 8; i++)
        r[b*8+i] = d[b*8+7-i];
    return r;
  endfunction

  function automatic logic [p_width-1:0] reflect_word(input logic [p_width-1:0] d);
    logic [p_width-1:0] r;
    r = '0;
    for (int i = 0; i < int'(p_width); i++)
      r[i] = d[p_width-1-i];
    return r;
  endfunction
`endif

  crc_state_t          state, state_nxt;
  logic                ready_en;
  logic                issued;
  logic                accept;
  logic                start;
  logic                cont;
  logic                err_nxt;
  logic                load_res;
  logic                advance;

  logic [p_width-1:0]  acc;
  logic [BEAT_W-1:0]   beats;
  logic [p_width-1:0]  step_seed;
  logic [p_data_w-1:0] step_data;
  logic [p_width-1:0]  step_out;
  logic [p_width-1:0]  final_crc;

  logic [p_width-1:0]  crc_p   [0:LAST];
  logic [BEAT_W-1:0]   beats_p [0:LAST];
  logic                vld_p   [0:LAST];

  // ---------------------------------------------------------------------------
  // Input conditioning and CRC step
  // ---------------------------------------------------------------------------
`ifdef CRC_REFLECT_EN
  assign step_data = reflect_bytes(in_data);
  assign final_crc = reflect_word(acc) ^ p_xorout;
`else
  assign step_data = in_data;
  assign final_crc = acc ^ p_xorout;
`endif

  // A start-of-frame beat always seeds from p_init, also when it aborts a
  // partial message in ACCUM.
  assign step_seed = in_sof ? p_init : acc;

  crc_step #(
    .p_width   (p_width),
    .p_polynom (p_polynom),
    .p_data_w  (p_data_w)
  ) u_step (
    .crc      (step_seed),
    .data     (step_data),
    .next_crc (step_out)
  );

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (start) state_nxt = in_last ? ST_HOLD : ST_ACCUM;
      end
      ST_ACCUM: begin
        if (accept && in_last) state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        if (issued && out_valid && out_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs and beat classification
  // ---------------------------------------------------------------------------
  always_comb begin
    // ready_en keeps in_ready low until the first clock edge after reset.
    in_ready = ready_en && (state != ST_HOLD);
    accept   = in_valid && in_ready;
    start    = accept && in_sof;
    cont     = accept && !in_sof && (state == ST_ACCUM);
    err_nxt  = accept && ((state == ST_IDLE) ? !in_sof : in_sof);
    load_res = (state == ST_HOLD) && !issued && advance;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      ready_en  <= 1'b0;
      issued    <= 1'b0;
      err_pulse <= 1'b0;
    end else begin
      ready_en  <= 1'b1;
      err_pulse <= err_nxt;
      if (load_res)                    issued <= 1'b1;
      else if (state_nxt == ST_IDLE)   issued <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Accumulator and beat counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      acc   <= p_init;
      beats <= '0;
    end else if (start) begin
      acc   <= step_out;
      beats <= BEAT_W'(1);
    end else if (cont) begin
      acc   <= step_out;
      beats <= sat_inc(beats);
    end
  end

  // ---------------------------------------------------------------------------
  // Output pipeline: stage 0 is the result register, stages 1..LAST are the
  // extra output registers. All stages move together or hold together.
  // ---------------------------------------------------------------------------
  assign advance = !vld_p[LAST] || out_ready;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int i = 0; i <= int'(LAST); i++) begin
        vld_p[i]   <= 1'b0;
        crc_p[i]   <= '0;
        beats_p[i] <= '0;
      end
    end else if (advance) begin
      vld_p[0] <= load_res;
      if (load_res) begin
        crc_p[0]   <= final_crc;
        beats_p[0] <= beats;
      end
      for (int i = 1; i <= int'(LAST); i++) begin
        vld_p[i]   <= vld_p[i-1];
        crc_p[i]   <= crc_p[i-1];
        beats_p[i] <= beats_p[i-1];
      end
    end
  end

  assign out_valid = vld_p[LAST];
  assign out_crc   = crc_p[LAST];
  assign out_beats = beats_p[LAST];

endmodule

// File: tb/tb_crc_stream_pipe.sv
// -----------------------------------------------------------------------------
// tb_crc_stream_pipe
// Directed bench for crc_stream_pipe. Two instances share the input bus:
//   dut8  : default CRC-8 (poly 0x31, init 0, xorout 0)
//   dut16 : CRC-16 (poly 0x1021, init 0xFFFF, xorout 0)
// sel picks which instance sees in_valid and whose outputs are observed.
// -----------------------------------------------------------------------------
module tb_crc_stream_pipe;

  localparam int STAGES = 1;
  localparam int LIMIT  = 100;

`ifdef CRC_REFLECT_EN
  localparam logic [15:0] EXP16 = 16'h6F91;
`else
  localparam logic [15:0] EXP16 = 16'h29B1;
`endif

  logic        clk = 1'b0;
  logic        rstN;
  logic        sel;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_sof;
  logic        in_last;
  logic        out_ready;

  logic        rdy8, rdy16, ov8, ov16, err8, err16;
  logic [7:0]  crc8;
  logic [15:0] crc16, beats8, beats16;
  logic        v8, v16;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign v8  = in_valid && !sel;
  assign v16 = in_valid && sel;

  crc_stream_pipe dut8 (
    .clk(clk), .rstN(rstN), .in_valid(v8), .in_ready(rdy8), .in_data(in_data),
    .in_sof(in_sof), .in_last(in_last), .out_valid(ov8), .out_ready(out_ready),
    .out_crc(crc8), .out_beats(beats8), .err_pulse(err8)
  );

  crc_stream_pipe #(
    .p_width(16), .p_polynom(16'h1021), .p_init(16'hFFFF), .p_xorout(16'h0000),
    .p_data_w(8), .p_out_stages(STAGES)
  ) dut16 (
    .clk(clk), .rstN(rstN), .in_valid(v16), .in_ready(rdy16), .in_data(in_data),
    .in_sof(in_sof), .in_last(in_last), .out_valid(ov16), .out_ready(out_ready),
    .out_crc(crc16), .out_beats(beats16), .err_pulse(err16)
  );

  logic        cur_ready, cur_valid, cur_err;
  logic [15:0] cur_crc, cur_beats;
  assign cur_ready = sel ? rdy16 : rdy8;
  assign cur_valid = sel ? ov16  : ov8;
  assign cur_err   = sel ? err16 : err8;
  assign cur_crc   = sel ? crc16 : {8'h00, crc8};
  assign cur_beats = sel ? beats16 : beats8;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Starts and ends on a falling edge; the beat is taken on the rising edge
  // where in_ready is seen high.
  task automatic beat(input logic [7:0] d, input logic sof, input logic last);
    int w;
    w        = 0;
    in_data  = d;
    in_sof   = sof;
    in_last  = last;
    in_valid = 1'b1;
    while (!cur_ready && w < LIMIT) begin
      @(negedge clk);
      w++;
    end
    check("beat_ready_timeout", (w < LIMIT) ? 32'd1 : 32'd0, 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send9();
    for (int i = 0; i < 9; i++)
      beat(8'h31 + 8'(i), i == 0, i == 8);
  endtask

  // Counts rising edges from the accepting edge until out_valid is seen.
  task automatic wait_out(output int lat);
    lat = 0;
    while (!cur_valid && lat < LIMIT) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic expect_result(input string tag, input logic [15:0] crc, input logic [15:0] nb);
    int lat;
    wait_out(lat);
    check({tag, "_latency"}, 32'(lat), 32'(1 + STAGES));
    check({tag, "_crc"},     {16'h0, cur_crc},   {16'h0, crc});
    check({tag, "_beats"},   {16'h0, cur_beats}, {16'h0, nb});
    @(negedge clk);
    check({tag, "_valid_drop"}, {31'h0, cur_valid}, 32'd0);
    check({tag, "_ready_back"}, {31'h0, cur_ready}, 32'd1);
  endtask

  initial begin
    int  lat;
    logic seen, stable, rdy_low;
    logic [15:0] held;

    sel = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_sof = 1'b0; in_last = 1'b0;
    out_ready = 1'b1; rstN = 1'b1;
    #2 rstN = 1'b0;
    #1;
    // Reset state
    check("rst_in_ready",  {31'h0, rdy8},  32'd0);
    check("rst_out_valid", {31'h0, ov8},   32'd0);
    check("rst_out_crc",   {24'h0, crc8},  32'd0);
    check("rst_out_beats", {16'h0, beats8}, 32'd0);
    check("rst_err",       {31'h0, err8},  32'd0);
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    #1 check("rst_ready_before_edge", {31'h0, rdy8}, 32'd0);
    @(negedge clk);
    check("rst_ready_after_edge", {31'h0, rdy8}, 32'd1);

    // CRC-8 instance
`ifdef CRC_REFLECT_EN
    send9();
    expect_result("crc8_reflect_check", 16'h00A1, 16'd9);
`else
    beat(8'h30, 1'b1, 1'b1);
    check("crc8_single_err", {31'h0, cur_err}, 32'd0);
    expect_result("crc8_0x30", 16'h00C5, 16'd1);
    beat(8'h80, 1'b1, 1'b1);
    expect_result("crc8_0x80", 16'h007A, 16'd1);
    beat(8'h00, 1'b1, 1'b0);
    beat(8'h01, 1'b0, 1'b1);
    expect_result("crc8_two_beat", 16'h0031, 16'd2);
`endif

    // CRC-16 instance: check string
    sel = 1'b1;
    @(negedge clk);
    send9();
    expect_result("crc16_check", EXP16, 16'd9);

    // Result stalled by out_ready low for 20 cycles with the next message waiting
    out_ready = 1'b0;
    send9();
    wait_out(lat);
    check("stall_latency", 32'(lat), 32'(1 + STAGES));
    held     = cur_crc;
    in_data  = 8'h31; in_sof = 1'b1; in_last = 1'b0; in_valid = 1'b1;
    stable   = 1'b1;
    rdy_low  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cur_crc !== held || cur_valid !== 1'b1) stable = 1'b0;
      if (cur_ready !== 1'b0) rdy_low = 1'b0;
    end
    check("stall_crc_value", {16'h0, held},    {16'h0, EXP16});
    check("stall_out_stable", {31'h0, stable},  32'd1);
    check("stall_ready_low",  {31'h0, rdy_low}, 32'd1);
    out_ready = 1'b1;
    send9();
    expect_result("after_stall", EXP16, 16'd9);

    // in_sof in the middle of a message restarts it
    beat(8'h31, 1'b1, 1'b0);
    beat(8'h32, 1'b0, 1'b0);
    beat(8'h33, 1'b0, 1'b0);
    check("restart_no_err_before", {31'h0, cur_err}, 32'd0);
    beat(8'h31, 1'b1, 1'b0);
    check("restart_err_pulse", {31'h0, cur_err}, 32'd1);
    @(negedge clk);
    check("restart_err_one_cycle", {31'h0, cur_err}, 32'd0);
    for (int i = 1; i < 9; i++)
      beat(8'h31 + 8'(i), 1'b0, i == 8);
    expect_result("restart_crc", EXP16, 16'd9);

    // Beat without in_sof while idle is dropped
    beat(8'h55, 1'b0, 1'b1);
    check("idle_nosof_err", {31'h0, cur_err}, 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (cur_valid) seen = 1'b1;
    end
    check("idle_nosof_no_output", {31'h0, seen}, 32'd0);
    check("idle_nosof_ready", {31'h0, cur_ready}, 32'd1);

    // Reset for one cycle in the middle of a message
    beat(8'h31, 1'b1, 1'b0);
    beat(8'h32, 1'b0, 1'b0);
    rstN = 1'b0;
    #1 check("midmsg_rst_ready", {31'h0, cur_ready}, 32'd0);
    @(negedge clk);
    rstN = 1'b1;
    #1 check("midmsg_rst_valid", {31'h0, cur_valid}, 32'd0);
    @(negedge clk);
    send9();
    expect_result("midmsg_rst_new", EXP16, 16'd9);

    // Reset while the result is in flight
    beat(8'h31, 1'b1, 1'b1);
    rstN = 1'b0;
    @(negedge clk);
    rstN = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (cur_valid) seen = 1'b1;
    end
    check("hold_rst_no_output", {31'h0, seen}, 32'd0);
    check("hold_rst_ready", {31'h0, cur_ready}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/crc_stream_pipe.md
CRC_STREAM_PIPE -- requirements
Module: crc_stream_pipe

Interface
REQ-001 p_width, 8, CRC register width in bits (4..32).
REQ-002 p_polynom, 8'h31, generator polynomial without the implicit top bit, p_width bits.
REQ-003 p_init, all-zeros, accumulator value loaded at start of message, p_width bits.
REQ-004 p_xorout, all-zeros, value XORed into the final CRC, p_width bits.
REQ-005 p_data_w, 8, data bits consumed per accepted beat (multiple of 8, 8..64).
REQ-006 p_out_stages, 1, extra output pipeline register stages (0..4).
REQ-007 clk  input  1  single clock; all logic on rising edge.
REQ-008 rstN  input  1  asynchronous active-low reset.
REQ-009 in_valid  input  1  beat present.
REQ-010 in_ready  output  1  beat accepted when in_valid and in_ready are both high.
REQ-011 in_data  input  p_data_w  message data; MSB processed first.
REQ-012 in_sof  input  1  first beat of a message.
REQ-013 in_last  input  1  final beat of a message.
REQ-014 out_valid  output  1  out_crc valid.
REQ-015 out_ready  input  1  downstream accepts result.
REQ-016 out_crc  output  p_width  final CRC.
REQ-017 out_beats  output  16  accepted beats in the message (saturates at 16'hFFFF).
REQ-018 err_pulse  output  1  one-cycle pulse on a protocol error.

Function
REQ-019 FSM states: IDLE, ACCUM, HOLD.
REQ-020 IDLE: in_ready=1; accepted beat with in_sof: acc = step(p_init, in_data), beats=1, then ACCUM (or HOLD if in_last).
REQ-021 IDLE: accepted beat without in_sof is dropped, err_pulse=1, state stays IDLE.
REQ-022 ACCUM: in_ready=1; each accepted beat sets acc = step(acc, in_data), beats+1; in_last -> HOLD.
REQ-023 ACCUM: accepted beat with in_sof discards the partial message, restarts as in REQ-020, err_pulse=1.
REQ-024 in_sof and in_last together form a single-beat message.
REQ-025 HOLD: result register = acc XOR p_xorout; in_ready=0 until the result leaves the final stage, then IDLE.
REQ-026 Latency from acceptance of the in_last beat to out_valid: 1 + p_out_stages cycles.
REQ-027 Output stages form a stall-all pipeline: out_crc, out_beats and out_valid hold while out_valid=1 and out_ready=0.
REQ-028 Exactly one result per message; out_valid drops the cycle after the handshake unless a new result reaches the final stage.
REQ-029 The step function is a bitwise-serial LFSR of p_width bits, unrolled over p_data_w bits in one cycle; there is no feedback across cycles other than acc.

Reset
REQ-030 rstN low asynchronously forces: state=IDLE, acc=p_init, beats=0, all stage valids=0, out_crc=0, out_beats=0, err_pulse=0, in_ready=0 while rstN is low.
REQ-031 Reset mid-message or mid-HOLD discards all partial and pending results; no output follows.
REQ-032 in_ready rises no earlier than the first rising clk edge after rstN deasserts.

Configuration
REQ-033 Macro CRC_REFLECT_EN defined: each input byte is bit-reversed before the step, and the final acc is bit-reversed over p_width before the p_xorout XOR.
REQ-034 CRC_REFLECT_EN undefined: no reflection logic is present; MSB-first non-reflected CRC.

Structure
REQ-035 Package crc_pkg holds the FSM state enum, the beat-counter width constant (16) and the maximum-width constants.
REQ-036 Sub-module crc_step: combinational, parameters p_width, p_polynom, p_data_w; inputs crc and data; output next crc.

Verification
REQ-037 p_width=8, p_polynom=8'h31, p_init=0, p_xorout=0, single beat 8'h30 with in_sof=1 and in_last=1 -> out_crc=8'hC5, out_beats=1, out_valid 1+p_out_stages cycles after acceptance.
REQ-038 p_width=16, p_polynom=16'h1021, p_init=16'hFFFF, p_xorout=0, ASCII "123456789" in nine 8-bit beats -> out_crc=16'h29B1, out_beats=9.
REQ-039 CRC_REFLECT_EN defined, p_width=8, p_polynom=8'h31, p_init=0, "123456789" -> out_crc=8'hA1.
REQ-040 Result pending with out_ready held low 20 cycles -> out_crc stable, in_ready=0 throughout; next message is accepted only after the handshake.
REQ-041 in_sof mid-message after 3 beats, then "123456789" (CRC-16 setup) -> err_pulse for one cycle, out_crc=16'h29B1, out_beats=9; a beat without sof in IDLE -> err_pulse, no output.
REQ-042 rstN low for 1 cycle mid-message, then a new message -> no stale output; the new message CRC is correct.
